// File: rtl/regfile_writeback.sv
// regfile_writeback
// Write-port arbiter for the integer register file. Single-cycle ALU results
// and buffered load responses share the file's one write port. Load responses
// wait in a small FIFO; writes to x0 are discarded on both paths. A per-register
// pending bit marks loads that are issued but not yet written back, so decode
// can stall on RAW hazards. A buffered load that keeps losing to ALU traffic
// raises stallReq until it gets written.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   aluValid/aluRd/aluData    ALU result (no back-pressure)
//   ldValid/ldReady/ldRd/ldData  load response handshake
//   issueValid/issueRd        load issue, sets the pending bit of its destination
//   rd/writeEnable/writeData  registered register-file write port
//   pending                   outstanding-load bitmap, bit 0 always 0
//   stallReq                  upstream must hold aluValid low
//   overrun                   sticky: an ALU write was dropped while stallReq was high
//   fifoCount                 current load FIFO occupancy
module regfile_writeback #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          aluValid,
    input  logic [4:0]                    aluRd,
    input  logic [31:0]                   aluData,
    input  logic                          ldValid,
    output logic                          ldReady,
    input  logic [4:0]                    ldRd,
    input  logic [31:0]                   ldData,
    input  logic                          issueValid,
    input  logic [4:0]                    issueRd,
    output logic [4:0]                    rd,
    output logic                          writeEnable,
    output logic [31:0]                   writeData,
    output logic [31:0]                   pending,
    output logic                          stallReq,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]          fifoRdR   [FIFO_DEPTH];
    logic [31:0]         fifoDataR [FIFO_DEPTH];
    logic [PTR_W-1:0]    headR;
    logic [PTR_W-1:0]    tailR;
    logic [STARVE_W-1:0] starveR;

    logic                fifoEmptyS;
    logic                aluWantS;
    logic                pushS;
    logic                popS;
    logic                aluWinS;
    logic                dropS;
    logic [STARVE_W-1:0] starveNextS;
    logic                stallNextS;
    logic [31:0]         pendingNextS;
    logic [CNT_W-1:0]    countNextS;

    // Ready comes from the registered count only; a full FIFO refuses even if it pops this cycle.
    assign ldReady = !rst && (fifoCount < CNT_W'(FIFO_DEPTH));

    // Arbitration: a starved load beats the ALU; otherwise the ALU wins and the FIFO drains in idle cycles.
    always_comb begin
        fifoEmptyS = (fifoCount == {CNT_W{1'b0}});
        aluWantS   = aluValid && (aluRd != 5'd0);
        pushS      = ldValid && ldReady && (ldRd != 5'd0);
        popS       = !fifoEmptyS && (stallReq || !aluWantS);
        aluWinS    = aluWantS && !stallReq;
        dropS      = aluWantS && stallReq;
    end

    // Starvation tracking: count consecutive ALU wins over a waiting load.
    always_comb begin
        starveNextS = starveR;
        stallNextS  = stallReq;
        if (popS || fifoEmptyS) begin
            starveNextS = {STARVE_W{1'b0}};
        end else if (aluWinS && (starveR != STARVE_W'(STARVE_LIMIT))) begin
            starveNextS = starveR + STARVE_W'(1);
        end else begin
            starveNextS = starveR;
        end
        if (popS) begin
            stallNextS = 1'b0;
        end else if (starveNextS == STARVE_W'(STARVE_LIMIT)) begin
            stallNextS = 1'b1;
        end else begin
            stallNextS = stallReq;
        end
    end

    // Pending scoreboard: clear on load writeback, then set on issue so a same-cycle set wins.
    always_comb begin
        pendingNextS = pending;
        if (popS) begin
            pendingNextS[fifoRdR[headR]] = 1'b0;
        end else begin
            pendingNextS = pending;
        end
        if (issueValid && (issueRd != 5'd0)) begin
            pendingNextS[issueRd] = 1'b1;
        end else begin
            pendingNextS[0] = 1'b0;
        end
        pendingNextS[0] = 1'b0;
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        case ({pushS, popS})
            2'b10:   countNextS = fifoCount + CNT_W'(1);
            2'b01:   countNextS = fifoCount - CNT_W'(1);
            default: countNextS = fifoCount;
        endcase
    end

    // FIFO storage; contents are meaningless until the count covers them, so no reset is needed.
    always_ff @(posedge clk) begin
        if (pushS) begin
            fifoRdR[tailR]   <= ldRd;
            fifoDataR[tailR] <= ldData;
        end
    end

    // Control state and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headR       <= {PTR_W{1'b0}};
            tailR       <= {PTR_W{1'b0}};
            fifoCount   <= {CNT_W{1'b0}};
            starveR     <= {STARVE_W{1'b0}};
            stallReq    <= 1'b0;
            overrun     <= 1'b0;
            pending     <= 32'd0;
            rd          <= 5'd0;
            writeEnable <= 1'b0;
            writeData   <= 32'd0;
        end else begin
            fifoCount <= countNextS;
            starveR   <= starveNextS;
            stallReq  <= stallNextS;
            overrun   <= overrun | dropS;
            pending   <= pendingNextS;
            if (pushS) begin
                tailR <= tailR + PTR_W'(1);
            end
            if (popS) begin
                headR       <= headR + PTR_W'(1);
                rd          <= fifoRdR[headR];
                writeData   <= fifoDataR[headR];
                writeEnable <= 1'b1;
            end else if (aluWinS) begin
                rd          <= aluRd;
                writeData   <= aluData;
                writeEnable <= 1'b1;
            end else begin
                writeEnable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int D     = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        ldValid;
    logic        ldReady;
    logic [4:0]  ldRd;
    logic [31:0] ldData;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic [4:0]  rd;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [31:0] pending;
    logic        stallReq;
    logic        overrun;
    logic [2:0]  fifoCount;

    regfile_writeback #(.FIFO_DEPTH(D), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData),
        .ldValid(ldValid), .ldReady(ldReady), .ldRd(ldRd), .ldData(ldData),
        .issueValid(issueValid), .issueRd(issueRd),
        .rd(rd), .writeEnable(writeEnable), .writeData(writeData),
        .pending(pending), .stallReq(stallReq), .overrun(overrun),
        .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;
    bit checkEn = 1'b0;

    // Behavioural model: a queue of waiting loads plus the visible write-port state.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    int          mStarve;
    bit          mStall;
    bit          mOverrun;
    bit          mWe;
    logic [4:0]  mRd;
    logic [31:0] mData;
    logic [31:0] mPend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mReset();
        q.delete();
        mStarve  = 0;
        mStall   = 1'b0;
        mOverrun = 1'b0;
        mWe      = 1'b0;
        mRd      = 5'd0;
        mData    = 32'd0;
        mPend    = 32'd0;
    endtask

    // One clock edge of the model, using the inputs held across that edge.
    task automatic modelStep();
        ent_t e;
        bit   hadEntries;
        bit   canAccept;
        bit   aluReq;
        bit   popped;
        if (rst) begin
            mReset();
            return;
        end
        hadEntries = (q.size() > 0);
        canAccept  = (q.size() < D);
        aluReq     = aluValid && (aluRd != 5'd0);
        popped     = 1'b0;
        if (hadEntries && (mStall || !aluReq)) begin
            e      = q.pop_front();
            mWe    = 1'b1;
            mRd    = e.r;
            mData  = e.d;
            popped = 1'b1;
            mPend[e.r] = 1'b0;
        end else if (aluReq && !mStall) begin
            mWe   = 1'b1;
            mRd   = aluRd;
            mData = aluData;
        end else begin
            mWe = 1'b0;
        end
        if (aluReq && mStall) mOverrun = 1'b1;
        if (popped || !hadEntries) mStarve = 0;
        else mStarve++;
        if (popped) mStall = 1'b0;
        else if (mStarve >= LIMIT) mStall = 1'b1;
        if (ldValid && canAccept && (ldRd != 5'd0)) begin
            e.r = ldRd;
            e.d = ldData;
            q.push_back(e);
        end
        if (issueValid && (issueRd != 5'd0)) mPend[issueRd] = 1'b1;
        mPend[0] = 1'b0;
    endtask

    // Compare process: DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            check("writeEnable", 32'(writeEnable), 32'(mWe));
            check("rd",          32'(rd),          32'(mRd));
            check("writeData",   writeData,        mData);
            check("pending",     pending,          mPend);
            check("stallReq",    32'(stallReq),    32'(mStall));
            check("overrun",     32'(overrun),     32'(mOverrun));
            check("fifoCount",   32'(fifoCount),   32'(q.size()));
            check("ldReady",     32'(ldReady),     32'(!rst && (q.size() < D)));
        end
    end

    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        #1;
    endtask

    task automatic idleInputs();
        aluValid = 1'b0; aluRd = 5'd0; aluData = 32'd0;
        ldValid = 1'b0; ldRd = 5'd0; ldData = 32'd0;
        issueValid = 1'b0; issueRd = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        mReset();
        cycle();
        cycle();
        check("reset_we", 32'(writeEnable), 32'd0);
        check("reset_ldReady", 32'(ldReady), 32'd0);
        rst = 1'b0;
        checkEn = 1'b1;

        // ALU write appears the next cycle, then drops.
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
        cycle();
        aluValid = 1'b0;
        check("alu_we", 32'(writeEnable), 32'd1);
        check("alu_rd", 32'(rd), 32'd5);
        check("alu_data", writeData, 32'hDEADBEEF);
        cycle();
        check("alu_we_drop", 32'(writeEnable), 32'd0);

        // Issued load stays pending until its writeback two cycles after handshake.
        issueValid = 1'b1; issueRd = 5'd7;
        cycle();
        issueValid = 1'b0;
        check("pend7_set", 32'(pending[7]), 32'd1);
        ldValid = 1'b1; ldRd = 5'd7; ldData = 32'h12345678;
        cycle();
        ldValid = 1'b0;
        check("ld_we_t1", 32'(writeEnable), 32'd0);
        check("ld_pend_t1", 32'(pending[7]), 32'd1);
        cycle();
        check("ld_we_t2", 32'(writeEnable), 32'd1);
        check("ld_rd_t2", 32'(rd), 32'd7);
        check("ld_data_t2", writeData, 32'h12345678);
        check("ld_pend_clr", 32'(pending[7]), 32'd0);

        // Four loads starved by ALU traffic on x9.
        aluValid = 1'b1; aluRd = 5'd9; aluData = 32'h00000909;
        for (int k = 1; k <= 4; k++) begin
            ldValid = 1'b1; ldRd = 5'(k); ldData = 32'h10000000 + 32'(k);
            cycle();
        end
        ldValid = 1'b0;
        check("full_count", 32'(fifoCount), 32'd4);
        check("full_ready", 32'(ldReady), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
        check("stall_not_yet", 32'(stallReq), 32'd0);
        cycle();
        check("stall_set", 32'(stallReq), 32'd1);
        cycle();
        check("stall_pop_rd", 32'(rd), 32'd1);
        check("stall_pop_data", writeData, 32'h10000001);
        check("stall_clr", 32'(stallReq), 32'd0);
        check("overrun_set", 32'(overrun), 32'd1);
        check("stall_count", 32'(fifoCount), 32'd3);
        aluValid = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        check("drain_rd", 32'(rd), 32'd4);
        check("drain_count", 32'(fifoCount), 32'd0);
        cycle();
        check("overrun_sticky", 32'(overrun), 32'd1);

        // x0 traffic on every path is ignored.
        for (int k = 0; k < 4; k++) begin
            aluValid = 1'b1; aluRd = 5'd0; aluData = 32'hFFFFFFFF;
            ldValid = 1'b1; ldRd = 5'd0; ldData = 32'hFFFFFFFF;
            issueValid = 1'b1; issueRd = 5'd0;
            cycle();
            check("x0_we", 32'(writeEnable), 32'd0);
            check("x0_count", 32'(fifoCount), 32'd0);
            check("x0_pend0", 32'(pending[0]), 32'd0);
        end
        idleInputs();

        // Asynchronous reset with three loads buffered.
        issueValid = 1'b1; issueRd = 5'd10;
        aluValid = 1'b1; aluRd = 5'd9; aluData = 32'h99;
        for (int k = 0; k < 3; k++) begin
            ldValid = 1'b1; ldRd = 5'(10 + k); ldData = 32'hA0 + 32'(k);
            cycle();
            issueValid = 1'b0;
        end
        idleInputs();
        check("pre_rst_count", 32'(fifoCount), 32'd3);
        rst = 1'b1;
        #1;
        check("arst_we", 32'(writeEnable), 32'd0);
        check("arst_rd", 32'(rd), 32'd0);
        check("arst_data", writeData, 32'd0);
        check("arst_count", 32'(fifoCount), 32'd0);
        check("arst_pend", pending, 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_ready", 32'(ldReady), 32'd0);
        mReset();
        cycle();
        rst = 1'b0;
        ldValid = 1'b1; ldRd = 5'd3; ldData = 32'hCAFEF00D;
        cycle();
        ldValid = 1'b0;
        cycle();
        check("post_rst_we", 32'(writeEnable), 32'd1);
        check("post_rst_rd", 32'(rd), 32'd3);
        check("post_rst_data", writeData, 32'hCAFEF00D);

        // Randomized traffic; upstream mostly honours stallReq.
        for (int n = 0; n < 3000; n++) begin
            aluValid   = ($urandom_range(0, 99) < 60) && (!mStall || ($urandom_range(0, 9) == 0));
            aluRd      = 5'($urandom_range(0, 12));
            aluData    = $urandom;
            ldValid    = ($urandom_range(0, 99) < 45);
            ldRd       = 5'($urandom_range(0, 12));
            ldData     = $urandom;
            issueValid = ($urandom_range(0, 99) < 30);
            issueRd    = 5'($urandom_range(0, 12));
            cycle();
        end
        idleInputs();
        cycle();

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-port arbiter for the integer register file: merges single-cycle ALU results with buffered long-latency load responses onto the file's one write port (rd, writeEnable, writeData). Buffers load responses in a small FIFO and drops x0 writes. Tracks per-register load-pending bits so decode can stall on RAW hazards. Raises a stall request when a buffered load has been starved by ALU traffic too long.

## Interface
- FIFO_DEPTH, 4, load-response FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive lost arbitration cycles before stallReq
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- aluValid  in  1  ALU result valid this cycle (no back-pressure)
- aluRd  in  5  ALU destination register
- aluData  in  32  ALU result
- ldValid  in  1  load response valid
- ldReady  out  1  load response accepted when ldValid && ldReady
- ldRd  in  5  load destination register
- ldData  in  32  load data
- issueValid  in  1  load issued this cycle
- issueRd  in  5  destination of issued load
- rd  out  5  register-file write address
- writeEnable  out  1  register-file write enable
- writeData  out  32  register-file write data
- pending  out  32  bit n = load to xn outstanding; bit 0 always 0
- stallReq  out  1  upstream must hold aluValid low
- overrun  out  1  sticky: ALU write dropped while stallReq high
- fifoCount  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset: rd, writeEnable, writeData, pending, stallReq, overrun, fifoCount all 0; FIFO empty; starve counter 0; ldReady 0 while rst high.
- ldReady = (fifoCount < FIFO_DEPTH), from registered count; no same-cycle pop bypass when full.
- Push: ldValid && ldReady && ldRd≠0. Handshake with ldRd=0 completes without enqueue.
- Output register loads every cycle; priority:
  - stallReq=1 and FIFO non-empty: pop head → output.
  - aluValid && aluRd≠0: ALU → output.
  - FIFO non-empty: pop head → output.
  - else writeEnable←0 (rd, writeData hold).
- aluValid with aluRd=0 counts as idle; FIFO may drain that cycle.
- aluValid && aluRd≠0 while stallReq=1: ALU write dropped, overrun←1 (cleared only by rst).
- Push and pop same cycle: count unchanged; FIFO ordering strictly in acceptance order; pointers wrap modulo FIFO_DEPTH.
- Starve counter: increments each cycle FIFO non-empty and ALU wins; resets to 0 on any pop or when FIFO empty. stallReq←1 on the edge counter reaches STARVE_LIMIT; stallReq←0 on the edge of the next pop.
- Scoreboard: issueValid && issueRd≠0 sets pending[issueRd]; FIFO pop to register n clears pending[n] on the same edge. Set and clear of same bit same cycle: set wins. ALU writes never clear pending.

## Timing
- ALU path: aluValid in cycle t → writeEnable high in t+1; register file commits at end of t+1.
- Load path, empty FIFO, no ALU: handshake in t → entry visible t+1 → writeEnable high t+2.
- Max one write per cycle; writeEnable deasserts in the first cycle with nothing to write.
- Asynchronous rst mid-operation: FIFO contents, pending and output discarded immediately; writeEnable drops without a clock edge.

## Test plan
- Reset, then aluValid=1 aluRd=5 aluData=0xDEADBEEF one cycle → next cycle rd=5 writeEnable=1 writeData=0xDEADBEEF, following cycle writeEnable=0.
- issueValid issueRd=7; later ldValid ldRd=7 ldData=0x12345678, ALU idle → pending[7]=1 until writeEnable=1 rd=7 two cycles after handshake, then pending[7]=0.
- Four loads (rd 1..4) with ALU busy every cycle on rd=9 → fifoCount=4, ldReady=0; after 8 ALU wins stallReq=1; next cycle pops rd=1, stallReq then 0.
- aluValid rd=9 while stallReq=1 → write dropped, overrun=1 and stays 1 until rst.
- aluRd=0 and ldRd=0 traffic → writeEnable never 1, fifoCount stays 0, pending[0]=0.
- Fill FIFO with 3 entries, assert rst mid-stream → all outputs 0 asynchronously, fifoCount=0, pending=0; post-reset load writes normally.
